mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_arb2.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 64;

    // Controller phase: clear every entry first, then serve requesters.
    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Identifies requester 0 or requester 1.
    typedef logic req_id_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way conflict arbiter: when both requesters want the same kind of
// access, the requester named by prio wins and prio passes to the loser.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic rd0,
    input  logic wr0,
    input  logic rd1,
    input  logic wr1,
    output logic ready0,
    output logic ready1
);

    req_id_t prio_q;
    req_id_t prio_d;
    logic    conflict;

    // A conflict is two reads or two writes; a read plus a write never conflict.
    always_comb begin
        conflict = (rd0 && rd1) || (wr0 && wr1);
        ready0   = en && !(conflict && (prio_q == 1'b1));
        ready1   = en && !(conflict && (prio_q == 1'b0));
        prio_d   = prio_q;
        if (en && conflict) begin
            prio_d = ~prio_q;
        end
    end

    // Priority flop: only a conflict cycle hands priority to the loser.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester front end for a 1R1W memory. A read and a write from different
// requesters are served together; like-for-like collisions go through rr_arb2.
// A read and write to the same entry in one cycle return the new data through
// a bypass register. Optional macro MEM_PORT_ARBITER_SCRUB_EN adds a start-up
// scrub that zeroes every entry before requesters are accepted.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    logic              run_q;
    logic              scrub_wen;
    logic [ADDR_W-1:0] scrub_addr;

`ifdef MEM_PORT_ARBITER_SCRUB_EN
    state_e            state_q;
    logic [ADDR_W-1:0] scrub_cnt_q;
    logic              scrub_wen_q;

    // Scrub sequencer: one idle cycle after reset, then one write per entry, then RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SCRUB;
            scrub_cnt_q <= '0;
            scrub_wen_q <= 1'b0;
            run_q       <= 1'b0;
        end else if (state_q == SCRUB) begin
            if (!scrub_wen_q) begin
                scrub_wen_q <= 1'b1;
            end else begin
                scrub_cnt_q <= scrub_cnt_q + 1'b1;
                if (&scrub_cnt_q) begin
                    scrub_wen_q <= 1'b0;
                    state_q     <= RUN;
                    run_q       <= 1'b1;
                end
            end
        end
    end

    assign scrub_wen  = scrub_wen_q;
    assign scrub_addr = scrub_cnt_q;
`else
    // Without scrub, requesters are served from the first clock after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign scrub_wen  = 1'b0;
    assign scrub_addr = '0;
`endif

    logic              rd0, wr0, rd1, wr1;
    logic              gnt0, gnt1;
    logic              wr_gnt, rd_gnt;
    req_id_t           wr_id, rd_id;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;

    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              rsp_valid_q, rsp_valid_d;
    req_id_t           rsp_id_q, rsp_id_d;
    logic              byp_q, byp_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;

    assign rd0 = req0_valid && !req0_write;
    assign wr0 = req0_valid &&  req0_write;
    assign rd1 = req1_valid && !req1_write;
    assign wr1 = req1_valid &&  req1_write;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .en     (run_q),
        .rd0    (rd0),
        .wr0    (wr0),
        .rd1    (rd1),
        .wr1    (wr1),
        .ready0 (req0_ready),
        .ready1 (req1_ready)
    );

    // Steer the granted write and read to the memory ports and stage the response.
    always_comb begin
        gnt0    = req0_valid && req0_ready;
        gnt1    = req1_valid && req1_ready;
        wr_gnt  = (gnt0 && req0_write) || (gnt1 && req1_write);
        rd_gnt  = (gnt0 && !req0_write) || (gnt1 && !req1_write);
        wr_id   = gnt1 && req1_write;
        rd_id   = gnt1 && !req1_write;
        wr_addr = wr_id ? req1_addr  : req0_addr;
        wr_data = wr_id ? req1_wdata : req0_wdata;
        rd_addr = rd_id ? req1_addr  : req0_addr;

        mem_wen   = scrub_wen || wr_gnt;
        mem_waddr = '0;
        mem_wdata = '0;
        if (scrub_wen) begin
            mem_waddr = scrub_addr;
        end else if (wr_gnt) begin
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end

        mem_raddr = rd_gnt ? rd_addr : raddr_q;
        raddr_d   = mem_raddr;

        rsp_valid_d = rd_gnt;
        rsp_id_d    = rd_gnt ? rd_id : rsp_id_q;
        // Memory is read-before-write, so a same-entry collision must return the new data.
        byp_d       = rd_gnt && wr_gnt && (rd_addr == wr_addr);
        byp_data_d  = wr_data;
    end

    // Response control and held read address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            raddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            byp_q       <= 1'b0;
        end else begin
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            byp_q       <= byp_d;
        end
    end

    // Bypass data is only consumed when byp_q is set, so it needs no reset.
    always_ff @(posedge clock) begin
        byp_data_q <= byp_data_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = byp_q ? byp_data_q : mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference
// model. Build with MEM_PORT_ARBITER_SCRUB_EN to exercise the start-up scrub.
module tb_mem_port_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp_valid, rsp_id;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata)
    );

    // Read-before-write synchronous memory attached to the DUT.
    logic [DW-1:0] mem_arr [DEPTH];
    always @(posedge clock) begin
        if (mem_wen) mem_arr[mem_waddr] <= mem_wdata;
        mem_rdata <= mem_arr[mem_raddr];
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];
    int            m_prio = 0;
    logic [AW-1:0] m_last_raddr = '0;

    // Last observed values, for directed checks.
    bit            s_rdy0, s_rdy1, s_rsp_valid, s_rsp_id;
    logic [DW-1:0] s_rsp_data;

    task automatic set_req(input bit v0, input bit w0, input int a0, input logic [DW-1:0] d0,
                           input bit v1, input bit w1, input int a1, input logic [DW-1:0] d1);
        req0_valid = v0; req0_write = w0; req0_addr = AW'(a0); req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = AW'(a1); req1_wdata = d1;
    endtask

    task automatic model_reset();
        m_prio       = 0;
        m_last_raddr = '0;
    endtask

    // Called just after a negedge with inputs applied; ends at the next negedge.
    task automatic step();
        bit            rd0, wr0, rd1, wr1, conf, g0, g1, wg, rg, n_known;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, n_data;
        bit            rid;
        #1;
        rd0  = req0_valid && !req0_write;
        wr0  = req0_valid &&  req0_write;
        rd1  = req1_valid && !req1_write;
        wr1  = req1_valid &&  req1_write;
        conf = (rd0 && rd1) || (wr0 && wr1);
        // In a collision only the priority holder is accepted; otherwise every valid requester is.
        g0 = req0_valid && !(conf && m_prio != 0);
        g1 = req1_valid && !(conf && m_prio != 1);
        s_rdy0 = req0_ready;
        s_rdy1 = req1_ready;
        if (req0_valid) chk("ready0", 64'(req0_ready), 64'(g0));
        if (req1_valid) chk("ready1", 64'(req1_ready), 64'(g1));
        wg = 0; rg = 0; wa = '0; ra = '0; wd = '0; rid = 0;
        if (g0 && wr0) begin wg = 1; wa = req0_addr; wd = req0_wdata; end
        if (g1 && wr1) begin wg = 1; wa = req1_addr; wd = req1_wdata; end
        if (g0 && rd0) begin rg = 1; ra = req0_addr; rid = 0; end
        if (g1 && rd1) begin rg = 1; ra = req1_addr; rid = 1; end
        chk("mem_wen", 64'(mem_wen), 64'(wg));
        if (wg) begin
            chk("mem_waddr", 64'(mem_waddr), 64'(wa));
            chk("mem_wdata", mem_wdata, wd);
        end
        if (rg) m_last_raddr = ra;
        chk("mem_raddr", 64'(mem_raddr), 64'(m_last_raddr));
        n_data  = '0;
        n_known = 0;
        if (rg) begin
            if (wg && wa == ra) begin
                n_data = wd; n_known = 1;
            end else begin
                n_data = ref_mem[ra]; n_known = ref_known[ra];
            end
        end
        if (wg) begin
            ref_mem[wa]   = wd;
            ref_known[wa] = 1;
        end
        if (conf) m_prio = (m_prio == 0) ? 1 : 0;
        @(negedge clock);
        s_rsp_valid = rsp_valid;
        s_rsp_id    = rsp_id;
        s_rsp_data  = rsp_rdata;
        chk("rsp_valid", 64'(rsp_valid), 64'(rg));
        if (rg) begin
            chk("rsp_id", 64'(rsp_id), 64'(rid));
            if (n_known) chk("rsp_rdata", rsp_rdata, n_data);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready0"}, 64'(req0_ready), 64'(0));
        chk({tag, "_ready1"}, 64'(req1_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
        chk({tag, "_mem_wen"}, 64'(mem_wen), 64'(0));
        chk({tag, "_mem_waddr"}, 64'(mem_waddr), 64'(0));
        chk({tag, "_mem_raddr"}, 64'(mem_raddr), 64'(0));
        chk({tag, "_mem_wdata"}, mem_wdata, 64'(0));
    endtask

`ifdef MEM_PORT_ARBITER_SCRUB_EN
    // Entered at the reset-release negedge; ends at the first negedge where requests are served.
    task automatic scrub(input int abort_at, output bit aborted);
        aborted = 0;
        set_req(1, 0, 4, '0, 1, 1, 9, '1);
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("scrub_wen", 64'(mem_wen), 64'(1));
            chk("scrub_waddr", 64'(mem_waddr), 64'(i));
            chk("scrub_wdata", mem_wdata, 64'(0));
            chk("scrub_ready0", 64'(req0_ready), 64'(0));
            chk("scrub_ready1", 64'(req1_ready), 64'(0));
            chk("scrub_rsp_valid", 64'(rsp_valid), 64'(0));
            if (i == abort_at) begin
                aborted = 1;
                return;
            end
            ref_mem[i]   = '0;
            ref_known[i] = 1;
            @(negedge clock);
        end
        set_req(0, 0, 0, '0, 0, 0, 0, '0);
    endtask
`endif

    // Release reset at a negedge and advance to the first cycle requests are served.
    task automatic release_and_ready();
        bit ab;
        @(negedge clock);
        set_req(0, 0, 0, '0, 0, 0, 0, '0);
        reset = 1'b1;
        model_reset();
`ifdef MEM_PORT_ARBITER_SCRUB_EN
        scrub(-1, ab);
`else
        ab = 0;
        @(negedge clock);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        ab = 0;
        set_req(1, 0, 1, '0, 1, 1, 2, 64'h55);
        repeat (3) @(negedge clock);
        #1;
        reset_checks("rst");

`ifdef MEM_PORT_ARBITER_SCRUB_EN
        // Reset in the middle of the scrub must restart it from entry 0.
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        scrub(10, ab);
        chk("scrub_abort_reached", 64'(ab), 64'(1));
        reset = 1'b0;
        #1;
        reset_checks("rst_mid_scrub");
        release_and_ready();
`else
        release_and_ready();
        // First cycle after release: a read to entry 0 is accepted and answered next cycle.
        set_req(1, 0, 0, '0, 0, 0, 0, '0);
        step();
        chk("first_read_ready", 64'(s_rdy0), 64'(1));
        chk("first_read_rsp", 64'(s_rsp_valid), 64'(1));
`endif

        // Write from req0 and read from req1 are accepted together.
        set_req(1, 1, 3, 64'hA5, 1, 0, 7, '0);
        step();
        chk("pair_ready0", 64'(s_rdy0), 64'(1));
        chk("pair_ready1", 64'(s_rdy1), 64'(1));
        chk("pair_rsp_valid", 64'(s_rsp_valid), 64'(1));
        chk("pair_rsp_id", 64'(s_rsp_id), 64'(1));

        // Same-entry write and read in one cycle return the new data.
        set_req(1, 1, 5, 64'hDEAD, 1, 0, 5, '0);
        step();
        chk("bypass_rsp_valid", 64'(s_rsp_valid), 64'(1));
        chk("bypass_data", s_rsp_data, 64'hDEAD);

        // Continuous read collisions alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            set_req(1, 0, 3, '0, 1, 0, 5, '0);
            step();
            chk("alt_ready0", 64'(s_rdy0), 64'(i % 2 == 0));
            chk("alt_ready1", 64'(s_rdy1), 64'(i % 2 == 1));
            chk("alt_rsp_id", 64'(s_rsp_id), 64'(i % 2));
        end

        // Write collisions also alternate.
        set_req(1, 1, 6, 64'h11, 1, 1, 6, 64'h22);
        step();
        set_req(1, 0, 6, '0, 0, 0, 0, '0);
        step();
        chk("wr_conflict_data", s_rsp_data, 64'h11);

        // Reset while a read response is pending drops it.
        set_req(1, 0, 2, '0, 0, 0, 0, '0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        reset_checks("rst_mid_read");
        release_and_ready();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            set_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                    {$urandom, $urandom},
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                    {$urandom, $urandom});
            step();
        end
        set_req(0, 0, 0, '0, 0, 0, 0, '0);
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
